// File: rtl/dual_port_ram_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_ram_ctl_if
// Description : Bundle of the write port, the read port and the status
//               signals of dual_port_ram_ctl.
//               master : drives wr_en/wr_addr/wr_data and rd_en/rd_addr,
//                        receives rd_data/rd_valid/busy
//               slave  : the RAM side (the opposite directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface dual_port_ram_ctl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/dual_port_ram_ctl.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_ram_ctl
// Description : Simple-dual-port RAM (one write port, one read port) with a
//               read latency of 1 or 2 cycles, a read-valid pulse, a
//               selectable read-during-write collision mode and a clear
//               sequencer that fills every word with CLR_VAL after reset.
// Ports       : clk - clock, all logic on the rising edge
//               rst - synchronous active-high reset, starts the clear
//               bus - dual_port_ram_ctl_if.slave (write port, read port,
//                     rd_data / rd_valid / busy)
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_ram_ctl #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       RD_LAT   = 1,
    parameter bit                WR_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input wire logic           clk,
    input wire logic           rst,
    dual_port_ram_ctl_if.slave bus
);
    localparam int unsigned       c_DEPTH    = 1 << ADDR_W;
    localparam logic [0:0]        c_ST_CLEAR = 1'b0;
    localparam logic [0:0]        c_ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] c_CLR_LAST = {ADDR_W{1'b1}};

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_run;
    logic              w_wr;
    logic              w_rd;
    logic              w_clr_we;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    // Both ports are dead while rst is high or the clear is still running.
    assign w_run    = (r_state == c_ST_RUN) && !rst;
    assign w_wr     = w_run && bus.wr_en;
    assign w_rd     = w_run && bus.rd_en;
    assign w_clr_we = (r_state == c_ST_CLEAR) && !rst;

    // The clear sequencer shares the single array write port.
    assign w_mem_we   = w_clr_we || w_wr;
    assign w_mem_addr = w_clr_we ? r_clr_cnt : bus.wr_addr;
    assign w_mem_data = w_clr_we ? CLR_VAL   : bus.wr_data;

    // Same-address bypass selects new data only in write-first mode; the
    // array itself always returns the pre-write contents.
    assign w_rd_word = (WR_FIRST && w_wr && (bus.wr_addr == bus.rd_addr))
                       ? bus.wr_data : r_mem[bus.rd_addr];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CLEAR: if (r_clr_cnt == c_CLR_LAST) w_state_nxt = c_ST_RUN;
            default:    w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == c_ST_CLEAR);
            // Wraps to 0 on the same edge that leaves CLEAR.
            if (w_clr_we) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        end
    end

    // Array: no reset, one write and one read per cycle.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd;
                    if (w_rd) r_rd_data <= w_rd_word;
                end
            end
        end else begin : g_lat2
            logic [DATA_W-1:0] r_s1_data;
            logic              r_s1_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_data  <= '0;
                    r_s1_valid <= 1'b0;
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_s1_valid <= w_rd;
                    if (w_rd) r_s1_data <= w_rd_word;
                    r_rd_valid <= r_s1_valid;
                    if (r_s1_valid) r_rd_data <= r_s1_data;
                end
            end
        end
    endgenerate

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = r_busy;
endmodule
`default_nettype wire
